line_buffer_sequencer: RTL and testbench
========================================

Name: line_buffer_sequencer

Overview:
- Controller that streams one 512x480 8-bit greyscale frame from frame memory into the five-line window buffer and drives its control inputs.
- Fetches 32-bit words (4 pixels) and issues buffer writes. Primes lead lines according to window size and flushes past the last line.
- Steps the window one column per handshake and presents each window to the downstream filter engine with valid/ready.
- Sits between the frame-memory read port and the convolution/filter engine.

Parameters:
- FRAME_BASE, 0, word address of pixel (0,0) in frame memory.
- ADDR_W, 16, width of memory word address.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begin a frame (ignored unless IDLE).
- size  in  2  window select: 0=2x2, 1=3x3, 3=5x5; 2 is invalid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last window accepted.
- rd_req  out  1  memory read request.
- rd_addr  out  ADDR_W  word address = FRAME_BASE + line*128 + word.
- rd_valid  in  1  read data valid; acknowledges the request.
- rd_data  in  32  read data; pixel 0 in bits [7:0].
- lb_datain  out  32  buffer write data.
- lb_address  out  9  column/pixel address.
- lb_vertical_count  out  9  centre line of the current window.
- lb_save_data  out  1  buffer write strobe.
- lb_next_matrix  out  1  rotate buffers one pixel.
- lb_size  out  2  registered copy of size.
- lb_matrix  in  200  window from buffers.
- win_matrix  out  200  = lb_matrix, passed through combinationally.
- win_valid  out  1  window valid.
- win_ready  in  1  consumer accepts window.

Behaviour:
- Reset: all state cleared to IDLE. Outputs reset to zero: busy, done, rd_req, lb_save_data, lb_next_matrix, win_valid, lb_address, lb_vertical_count, lb_datain, lb_size. Reset mid-frame abandons the frame with no done pulse.
- Lead L: 1 for size 0 and 1; 2 for size 3.
- start with size=2: ignored; stays IDLE, busy=0.
- start in IDLE with valid size: latch size into lb_size; busy=1; set next_load=0 and centre=0; go to FETCH.
- FETCH loads one line, word w = 0..127:
  - Hold rd_req=1 and rd_addr stable until rd_valid.
  - Cycle after rd_valid: lb_save_data=1, lb_datain=rd_data (registered), lb_address=w*4. rd_req stays low that cycle.
  - The write of w=0 has address 0, which shifts the line buffers.
  - After w=127 is written, next_load++.
  - If next_load <= centre+L, stay in FETCH (priming).
  - Otherwise lb_address=0 and go to COMPUTE.
- FLUSH: used instead of FETCH when next_load > 479. Issues 128 lb_save_data writes with lb_datain=0, one per cycle, no memory reads. Edge masking makes the contents irrelevant, but the shift is required.
- COMPUTE:
  - lb_vertical_count=centre. win_valid=1. lb_address=column, starting at 0.
  - On win_valid & win_ready: lb_next_matrix=1 that cycle and column++.
  - After the handshake at column 511: column wraps to 0 and the buffers are back in original alignment.
  - If centre==479: go to DONE. Otherwise centre++; if next_load<=479 go to FETCH, else FLUSH.
- DONE: done=1 for one cycle, busy=0, back to IDLE.
- Mutual exclusion: lb_save_data and lb_next_matrix are never high together. win_valid is low outside COMPUTE.
- Stalls: win_valid stays asserted while win_ready=0; the window and column are held. rd_valid without rd_req is ignored.
- Counters: column 9 bits, wraps 511->0. centre and next_load are 10 bits internally so that 480 can be compared.
- Per frame: 480*512 = 245760 window handshakes. Memory reads = 61440 words (every line read exactly once).

Test Plan:
- Reset during FETCH at word 37, then release: all outputs 0 and IDLE. A new start re-reads from rd_addr=FRAME_BASE.
- size=1, memory word value = line index replicated in every byte, ready always high:
  - First window has centre=0; num4 byte = 0x00, num7 byte = 0x01.
  - Reads before the first win_valid = 256.
  - done after 245760 handshakes; total reads = 61440.
- size=3:
  - Reads before the first win_valid = 384.
  - At centre 478 and 479, FLUSH occurs (no rd_req); window rows from line 480+ are zero.
  - done pulses once.
- size=2 start: busy stays 0, no rd_req, no done.
- Random win_ready (50%), size=0:
  - Window held stable while stalled.
  - lb_next_matrix count equals handshake count.
  - lb_address sequence 0..511 per line.
- Memory with rd_valid latency of 5 cycles: rd_addr held stable during the wait; each word written exactly once; start pulsed while busy is ignored.

Source files
------------

// File: rtl/line_buffer_sequencer.sv
// Streams one greyscale frame from frame memory into the five-line window buffer
// and hands each window position to the filter engine over valid/ready.
module line_buffer_sequencer #(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
  parameter int unsigned       LINES      = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        size,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic [31:0]       lb_datain,
  output logic [8:0]        lb_address,
  output logic [8:0]        lb_vertical_count,
  output logic              lb_save_data,
  output logic              lb_next_matrix,
  output logic [1:0]        lb_size,
  input  logic [199:0]      lb_matrix,
  output logic [199:0]      win_matrix,
  output logic              win_valid,
  input  logic              win_ready
);

  typedef enum logic [2:0] {StIdle, StFetch, StFlush, StCompute, StDone} state_e;

  localparam logic [9:0] LastLine = 10'(LINES - 1);

  state_e      state_q, state_d;
  logic [9:0]  next_load_q, next_load_d;
  logic [9:0]  centre_q, centre_d;
  logic [6:0]  word_q, word_d;
  logic [8:0]  column_q, column_d;
  logic        wr_q, wr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;

  logic [9:0]  lead;
  logic [9:0]  next_load_inc;
  state_e      line_next;

  assign lead          = (size_q == 2'd3) ? 10'd2 : 10'd1;
  assign next_load_inc = next_load_q + 10'd1;

  // After a line lands: keep priming until the lead lines are in, past the frame only shift zeros.
  assign line_next = (next_load_inc <= centre_q + lead) ?
                     ((next_load_inc > LastLine) ? StFlush : StFetch) : StCompute;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      next_load_q <= '0;
      centre_q    <= '0;
      word_q      <= '0;
      column_q    <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      next_load_q <= next_load_d;
      centre_q    <= centre_d;
      word_q      <= word_d;
      column_q    <= column_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      size_q      <= size_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    next_load_d    = next_load_q;
    centre_d       = centre_q;
    word_d         = word_q;
    column_d       = column_q;
    wr_d           = wr_q;
    data_d         = data_q;
    size_d         = size_q;
    rd_req         = 1'b0;
    lb_next_matrix = 1'b0;
    win_valid      = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && size != 2'd2) begin
          size_d      = size;
          next_load_d = '0;
          centre_d    = '0;
          word_d      = '0;
          column_d    = '0;
          wr_d        = 1'b0;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        if (wr_q) begin
          wr_d   = 1'b0;
          word_d = word_q + 7'd1;
          if (word_q == 7'd127) begin
            next_load_d = next_load_inc;
            state_d     = line_next;
          end
        end else begin
          rd_req = 1'b1;
          if (rd_valid) begin
            wr_d   = 1'b1;
            data_d = rd_data;
          end
        end
      end
      StFlush: begin
        word_d = word_q + 7'd1;
        if (word_q == 7'd127) begin
          next_load_d = next_load_inc;
          state_d     = line_next;
        end
      end
      StCompute: begin
        win_valid = 1'b1;
        if (win_ready) begin
          lb_next_matrix = 1'b1;
          column_d       = column_q + 9'd1;
          if (column_q == 9'd511) begin
            if (centre_q == LastLine) begin
              state_d = StDone;
            end else begin
              centre_d = centre_q + 10'd1;
              state_d  = (next_load_q <= LastLine) ? StFetch : StFlush;
            end
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy         = (state_q == StFetch) || (state_q == StFlush) || (state_q == StCompute);
  assign lb_save_data = ((state_q == StFetch) && wr_q) || (state_q == StFlush);
  assign lb_datain    = (state_q == StFetch) ? data_q : '0;
  assign lb_address   = (state_q == StCompute) ? column_q :
                        ((state_q == StFetch) || (state_q == StFlush)) ? {word_q, 2'b00} : '0;
  assign lb_vertical_count = centre_q[8:0];
  assign lb_size      = size_q;
  assign rd_addr      = FRAME_BASE + ADDR_W'({next_load_q, word_q});
  assign win_matrix   = lb_matrix;

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Directed bench for line_buffer_sequencer on a shortened frame, with a memory responder,
// a buffer stand-in and a negedge monitor that tracks per-frame counts and ordering errors.
module tb_line_buffer_sequencer;

  localparam int unsigned       ADDR_W = 16;
  localparam logic [15:0]       BASE   = 16'h0400;
  localparam int unsigned       LINES  = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, rd_req, rd_valid;
  logic [1:0]    size, lb_size;
  logic [15:0]   rd_addr;
  logic [31:0]   rd_data, lb_datain;
  logic [8:0]    lb_address, lb_vertical_count;
  logic          lb_save_data, lb_next_matrix, win_valid, win_ready;
  logic [199:0]  lb_matrix, win_matrix;

  int total = 0, bad = 0;
  int mem_lat = 0, lat_cnt = 0;

  // Monitor state
  int frame_reads = 0, frame_saves = 0, frame_hs = 0, frame_next = 0, first_win_reads = 0;
  int done_cnt = 0, rdreq_cnt = 0, nm_cnt = 0;
  int save_err = 0, addr_err = 0, stable_err = 0, excl_err = 0, pass_err = 0, col_err = 0;
  int done_hs = 0, done_reads = 0, done_saves = 0, done_next = 0;

  line_buffer_sequencer #(
    .ADDR_W    (ADDR_W),
    .FRAME_BASE(BASE),
    .LINES     (LINES)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .size             (size),
    .busy             (busy),
    .done             (done),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .lb_datain        (lb_datain),
    .lb_address       (lb_address),
    .lb_vertical_count(lb_vertical_count),
    .lb_save_data     (lb_save_data),
    .lb_next_matrix   (lb_next_matrix),
    .lb_size          (lb_size),
    .lb_matrix        (lb_matrix),
    .win_matrix       (win_matrix),
    .win_valid        (win_valid),
    .win_ready        (win_ready)
  );

  initial forever #5 clk = ~clk;

  // Memory: answers a pending request after mem_lat idle cycles with the line index in every byte.
  initial begin
    int line;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_valid) begin
        rd_valid = 1'b0;
      end else if (rd_req) begin
        if (lat_cnt >= mem_lat) begin
          line     = (int'(rd_addr) - int'(BASE)) / 128;
          rd_data  = {4{8'(line)}};
          rd_valid = 1'b1;
          lat_cnt  = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Buffer stand-in: the window changes only when the buffers rotate.
  initial begin
    lb_matrix = '0;
    forever begin
      @(posedge clk); #1;
      lb_matrix = {nm_cnt[7:0], {6{nm_cnt}}};
    end
  end

  initial begin
    logic         prev_busy = 1'b0, prev_pend = 1'b0, prev_stall = 1'b0, got_win = 1'b0;
    logic [15:0]  prev_addr = '0;
    logic [8:0]   prev_lbaddr = '0;
    logic [199:0] prev_mat = '0;
    logic [31:0]  exp_data;
    int           line;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy  = 1'b0;
        prev_pend  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          frame_reads = 0; frame_saves = 0; frame_hs = 0; frame_next = 0; got_win = 1'b0;
        end
        if (rd_req) rdreq_cnt++;
        if (prev_pend && rd_req && rd_addr !== prev_addr) stable_err++;
        if (rd_req && rd_valid) begin
          if (rd_addr !== 16'(int'(BASE) + frame_reads)) addr_err++;
          frame_reads++;
        end
        if (lb_save_data) begin
          line     = frame_saves / 128;
          exp_data = (line < int'(LINES)) ? {4{8'(line)}} : 32'd0;
          if (lb_datain !== exp_data || lb_address !== {7'(frame_saves % 128), 2'b00})
            save_err++;
          frame_saves++;
        end
        if (lb_save_data && (lb_next_matrix || win_valid)) excl_err++;
        if (win_matrix !== lb_matrix) pass_err++;
        if (win_valid) begin
          if (!got_win) first_win_reads = frame_reads;
          got_win = 1'b1;
          if (lb_address !== 9'(frame_hs % 512) || lb_vertical_count !== 9'(frame_hs / 512))
            col_err++;
        end
        if (prev_stall && (!win_valid || win_matrix !== prev_mat || lb_address !== prev_lbaddr))
          stable_err++;
        if (win_valid && win_ready) frame_hs++;
        if (lb_next_matrix) begin
          frame_next++;
          nm_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_hs = frame_hs; done_reads = frame_reads;
          done_saves = frame_saves; done_next = frame_next;
        end
        prev_busy   = busy;
        prev_pend   = rd_req && !rd_valid;
        prev_addr   = rd_addr;
        prev_stall  = win_valid && !win_ready;
        prev_mat    = win_matrix;
        prev_lbaddr = lb_address;
      end
    end
  end

  task automatic pulse_start(input logic [1:0] s);
    @(posedge clk); #1;
    size  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit rnd_ready, input string name);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd_ready) win_ready = 1'($urandom_range(0, 1));
      n++;
    end
    win_ready = 1'b1;
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles, want done", name, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    int d0;
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 5;
    if ({busy, done, rd_req, lb_save_data, lb_next_matrix, win_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000",
                      {busy, done, rd_req, lb_save_data, lb_next_matrix, win_valid});
    end
    if (lb_address !== 9'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", lb_address); end
    if (lb_vertical_count !== 9'd0) begin
      bad++; $display("FAIL reset_vcount: got %0d want 0", lb_vertical_count);
    end
    if (lb_datain !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", lb_datain); end
    if (lb_size !== 2'd0) begin bad++; $display("FAIL reset_size: got %0d want 0", lb_size); end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Abandon a frame while fetching word 37 of line 0
    pulse_start(2'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(frame_saves == 37 && rd_req) && n < 2000);
    total++;
    if (rd_addr !== BASE + 16'd37) begin
      bad++; $display("FAIL word37_addr: got %h want %h", rd_addr, BASE + 16'd37);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total += 2;
    if ({busy, done, rd_req, lb_save_data, lb_next_matrix, win_valid} !== 6'b0) begin
      bad++; $display("FAIL midreset_ctrl: got %b want 000000",
                      {busy, done, rd_req, lb_save_data, lb_next_matrix, win_valid});
    end
    if ({lb_address, lb_vertical_count, lb_datain, lb_size} !== 52'd0) begin
      bad++; $display("FAIL midreset_data: got %h want 0",
                      {lb_address, lb_vertical_count, lb_datain, lb_size});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start(2'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_req && n < 50);
    total += 2;
    if (rd_addr !== BASE || !rd_req) begin
      bad++; $display("FAIL restart_addr: got %h req %b want %h req 1", rd_addr, rd_req, BASE);
    end
    if (done_cnt != d0) begin bad++; $display("FAIL reset_no_done: got %0d want %0d", done_cnt, d0); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_size1;
    int d0 = done_cnt;
    mem_lat = 0;
    pulse_start(2'd1);
    run_to_done(20000, 1'b0, "size1");
    total += 7;
    if (first_win_reads != 256) begin
      bad++; $display("FAIL s1_prime_reads: got %0d want 256", first_win_reads);
    end
    if (done_hs != int'(LINES) * 512) begin
      bad++; $display("FAIL s1_handshakes: got %0d want %0d", done_hs, LINES * 512);
    end
    if (done_reads != int'(LINES) * 128) begin
      bad++; $display("FAIL s1_reads: got %0d want %0d", done_reads, LINES * 128);
    end
    if (done_saves != int'(LINES + 1) * 128) begin
      bad++; $display("FAIL s1_writes: got %0d want %0d", done_saves, (LINES + 1) * 128);
    end
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL s1_done: got %0d pulses busy %b want 1 busy 0", done_cnt - d0, busy);
    end
    if (save_err + addr_err != 0) begin
      bad++; $display("FAIL s1_write_seq: got %0d/%0d errors want 0", save_err, addr_err);
    end
    if (col_err + excl_err + pass_err != 0) begin
      bad++; $display("FAIL s1_window: got %0d/%0d/%0d errors want 0", col_err, excl_err, pass_err);
    end
  endtask

  task automatic test_size3;
    int d0 = done_cnt;
    pulse_start(2'd3);
    run_to_done(20000, 1'b0, "size3");
    total += 6;
    if (first_win_reads != 384) begin
      bad++; $display("FAIL s3_prime_reads: got %0d want 384", first_win_reads);
    end
    if (done_reads != int'(LINES) * 128) begin
      bad++; $display("FAIL s3_reads: got %0d want %0d", done_reads, LINES * 128);
    end
    if (done_saves != int'(LINES + 2) * 128) begin
      bad++; $display("FAIL s3_flush_writes: got %0d want %0d", done_saves, (LINES + 2) * 128);
    end
    if (done_hs != int'(LINES) * 512) begin
      bad++; $display("FAIL s3_handshakes: got %0d want %0d", done_hs, LINES * 512);
    end
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL s3_done_once: got %0d want 1", done_cnt - d0);
    end
    if (save_err + col_err + excl_err != 0) begin
      bad++; $display("FAIL s3_seq: got %0d/%0d/%0d errors want 0", save_err, col_err, excl_err);
    end
  endtask

  task automatic test_invalid_size;
    int d0  = done_cnt;
    int rq0 = rdreq_cnt;
    int busy_cycles = 0;
    pulse_start(2'd2);
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    total += 3;
    if (busy_cycles != 0) begin bad++; $display("FAIL inv_busy: got %0d want 0", busy_cycles); end
    if (rdreq_cnt != rq0) begin bad++; $display("FAIL inv_rdreq: got %0d want 0", rdreq_cnt - rq0); end
    if (done_cnt != d0) begin bad++; $display("FAIL inv_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_stall;
    pulse_start(2'd0);
    run_to_done(40000, 1'b1, "stall");
    total += 5;
    if (done_hs != int'(LINES) * 512) begin
      bad++; $display("FAIL st_handshakes: got %0d want %0d", done_hs, LINES * 512);
    end
    if (done_next != int'(LINES) * 512) begin
      bad++; $display("FAIL st_next_matrix: got %0d want %0d", done_next, LINES * 512);
    end
    if (stable_err != 0) begin bad++; $display("FAIL st_hold: got %0d errors want 0", stable_err); end
    if (col_err != 0) begin bad++; $display("FAIL st_column_seq: got %0d errors want 0", col_err); end
    if (first_win_reads != 256 || lb_size !== 2'd0) begin
      bad++; $display("FAIL st_size0: got %0d reads size %0d want 256 size 0", first_win_reads, lb_size);
    end
  endtask

  task automatic test_latency;
    int d0 = done_cnt;
    mem_lat = 5;
    pulse_start(2'd1);
    repeat (300) @(posedge clk);
    pulse_start(2'd3);
    run_to_done(40000, 1'b0, "latency");
    mem_lat = 0;
    total += 5;
    if (stable_err + addr_err != 0) begin
      bad++; $display("FAIL lat_addr_hold: got %0d/%0d errors want 0", stable_err, addr_err);
    end
    if (done_reads != int'(LINES) * 128) begin
      bad++; $display("FAIL lat_reads: got %0d want %0d", done_reads, LINES * 128);
    end
    if (done_saves != int'(LINES + 1) * 128 || save_err != 0) begin
      bad++; $display("FAIL lat_writes: got %0d err %0d want %0d err 0",
                      done_saves, save_err, (LINES + 1) * 128);
    end
    if (lb_size !== 2'd1) begin bad++; $display("FAIL lat_busy_start: got size %0d want 1", lb_size); end
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL lat_done: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    size      = 2'd0;
    win_ready = 1'b1;
    test_reset;
    test_size1;
    test_size3;
    test_invalid_size;
    test_stall;
    test_latency;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
